// File: rtl/adder_sequencer.sv
// Multi-cycle add/subtract sequencer: walks the operands through an
// external WIDTH-bit adder one slice per clock, rippling the carry
// between cycles, and registers the N-bit result on completion.
module adder_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SLICES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      carry_in,
  input  logic [WIDTH*SLICES-1:0]   a,
  input  logic [WIDTH*SLICES-1:0]   b,
  output logic [WIDTH-1:0]          adder_x,
  output logic [WIDTH-1:0]          adder_y,
  output logic                      adder_cin,
  input  logic [WIDTH-1:0]          adder_z,
  input  logic                      adder_cout,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*SLICES-1:0]   result,
  output logic                      carry_out,
  output logic                      overflow
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_next;
  logic [SLICES-1:0][WIDTH-1:0]  a_q, b_q, acc_q, acc_next;
  logic                          cin0_q, carry_q;
  logic [KW-1:0]                 k_q;
  logic                          last;

  assign last = (k_q == K_LAST);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: IDLE waits for start, RUN walks slices, DONE is a single cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder drive: only the current slice is presented, zero outside RUN
  always_comb begin
    adder_x   = '0;
    adder_y   = '0;
    adder_cin = 1'b0;
    if (state == RUN) begin
      adder_x   = a_q[k_q];
      adder_y   = b_q[k_q];
      adder_cin = (k_q == '0) ? cin0_q : carry_q;
    end
  end

  // Accumulator with the slice being returned merged in, so the final
  // slice can be committed to result on the same edge it arrives
  always_comb begin
    acc_next      = acc_q;
    acc_next[k_q] = adder_z;
  end

  // Operand capture, slice accumulation and result commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cin0_q    <= 1'b0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Subtraction is a + ~b + 1, so invert b and force the carry-in
          a_q    <= a;
          b_q    <= sub ? ~b : b;
          cin0_q <= sub | carry_in;
          k_q    <= '0;
        end
        RUN: begin
          acc_q   <= acc_next;
          carry_q <= adder_cout;
          k_q     <= last ? '0 : k_q + KW'(1);
          if (last) begin
            result    <= acc_next;
            carry_out <= adder_cout;
            overflow  <= (a_q[SLICES-1][WIDTH-1] == b_q[SLICES-1][WIDTH-1]) &&
                         (adder_z[WIDTH-1] != a_q[SLICES-1][WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: models the external slice adder, keeps an
// arithmetic reference of each operation and compares every cycle.
module tb_adder_sequencer;
  localparam int WIDTH  = 8;
  localparam int SLICES = 4;
  localparam int N      = WIDTH * SLICES;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic             carry_in = 1'b0;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic [WIDTH-1:0] adder_x, adder_y, adder_z;
  logic             adder_cin, adder_cout;
  logic             busy, done, carry_out, overflow;
  logic [N-1:0]     result;

  int checks = 0;
  int errors = 0;

  adder_sequencer #(.WIDTH(WIDTH), .SLICES(SLICES)) dut (
    .clock(clock), .reset(reset), .start(start), .sub(sub), .carry_in(carry_in),
    .a(a), .b(b), .adder_x(adder_x), .adder_y(adder_y), .adder_cin(adder_cin),
    .adder_z(adder_z), .adder_cout(adder_cout), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  // External combinational slice adder
  assign {adder_cout, adder_z} = {1'b0, adder_x} + {1'b0, adder_y} + {{WIDTH{1'b0}}, adder_cin};

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer math
  function automatic void ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic s, input logic c,
                                 output logic [N-1:0] r, output logic co, output logic ov);
    longint sx, sy, sr;
    logic [N:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
      r  = u[N-1:0];
      co = u[N];
      sr = sx + sy + longint'(c);
    end
    ov = (sr > (longint'(1) << (N-1)) - 1) || (sr < -(longint'(1) << (N-1)));
  endfunction

  // Reference model: countdown of remaining busy cycles plus pending results
  int           cnt = 0;
  logic [N-1:0] m_a = '0, m_bp = '0, m_res = '0, p_res = '0;
  logic         m_cin0 = 1'b0, m_co = 1'b0, m_ov = 1'b0, p_co = 1'b0, p_ov = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt = 0; m_res = '0; m_co = 1'b0; m_ov = 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        m_a    = a;
        m_bp   = sub ? ~b : b;
        m_cin0 = sub ? 1'b1 : carry_in;
        ref_op(a, b, sub, carry_in, p_res, p_co, p_ov);
        cnt = SLICES + 1;
      end
    end else begin
      cnt = cnt - 1;
      if (cnt == 1) begin
        m_res = p_res; m_co = p_co; m_ov = p_ov;
      end
    end
  end

  // Carry entering bit k*WIDTH of a + b' + cin0
  function automatic logic carry_into(input int k);
    logic [N:0] mask, lo;
    mask = ((N+1)'(1) << (k * WIDTH)) - (N+1)'(1);
    lo   = ({1'b0, m_a} & mask) + ({1'b0, m_bp} & mask) + {{N{1'b0}}, m_cin0};
    return lo[k * WIDTH];
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    logic [WIDTH-1:0] ex, ey;
    logic ec;
    int k;
    ex = '0; ey = '0; ec = 1'b0;
    if (cnt >= 2) begin
      k  = SLICES + 1 - cnt;
      ex = m_a[k*WIDTH +: WIDTH];
      ey = m_bp[k*WIDTH +: WIDTH];
      ec = carry_into(k);
    end
    chk("busy", 64'(busy), 64'(cnt != 0));
    chk("done", 64'(done), 64'(cnt == 1));
    chk("result", 64'(result), 64'(m_res));
    chk("carry_out", 64'(carry_out), 64'(m_co));
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("adder_x", 64'(adder_x), 64'(ex));
    chk("adder_y", 64'(adder_y), 64'(ey));
    chk("adder_cin", 64'(adder_cin), 64'(ec));
  end

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_result"}, 64'(result), 0);
    chk({tag, "_cout"}, 64'(carry_out), 0);
    chk({tag, "_ovf"}, 64'(overflow), 0);
    chk({tag, "_xyc"}, 64'({adder_x, adder_y, adder_cin}), 0);
  endtask

  // Launch one operation and wait (bounded) for done; returns results,
  // the negedge index of done after the start edge and the adder_cin trail
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s, input logic c,
                       output logic [N-1:0] r, output logic co, output logic ov,
                       output int done_at, output logic [7:0] seq);
    bit found;
    found = 0; done_at = -1; seq = '0; r = '0; co = 0; ov = 0;
    @(negedge clock);
    a = x; b = y; sub = s; carry_in = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      if (j > 0) @(negedge clock);
      if (done) begin
        found = 1; done_at = j; r = result; co = carry_out; ov = overflow;
      end else if (j < 8) begin
        seq[j] = adder_cin;
      end
    end
    if (!found) chk("op_timeout", 0, 1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic co, ov;
    int dat, ndone;
    logic [7:0] seq;
    logic [N-1:0] corner [4];
    corner[0] = '0; corner[1] = '1; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

    // Reset holds everything at zero, and it stays so after release
    repeat (2) @(negedge clock);
    all_zero("rst_hold");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    all_zero("rst_idle");

    // Carry chain across slice 0 -> 1
    do_op(32'h0000_00FF, 32'h0000_0001, 0, 0, r, co, ov, dat, seq);
    chk("chain_result", 64'(r), 64'h100);
    chk("chain_cout", 64'(co), 0);
    chk("chain_ovf", 64'(ov), 0);
    chk("chain_latency", 64'(dat), 4);
    chk("chain_cin_seq", 64'(seq[3:0]), 64'b0010);

    // Wrap-around with carry-in
    do_op(32'hFFFF_FFFF, 32'h0, 0, 1, r, co, ov, dat, seq);
    chk("wrap_result", 64'(r), 0);
    chk("wrap_cout", 64'(co), 1);
    chk("wrap_ovf", 64'(ov), 0);

    // Subtraction, including carry_in ignored and signed overflow
    do_op(32'd5, 32'd7, 1, 0, r, co, ov, dat, seq);
    chk("sub_result", 64'(r), 64'hFFFF_FFFE);
    chk("sub_cout", 64'(co), 0);
    chk("sub_ovf", 64'(ov), 0);
    do_op(32'h8000_0000, 32'h1, 1, 1, r, co, ov, dat, seq);
    chk("subov_result", 64'(r), 64'h7FFF_FFFF);
    chk("subov_cout", 64'(co), 1);
    chk("subov_ovf", 64'(ov), 1);

    // start held through RUN with operands changing: one done, first operands win
    @(negedge clock);
    a = 32'h10; b = 32'h20; sub = 0; carry_in = 0; start = 1'b1;
    ndone = 0;
    for (int j = 0; j < 12 && ndone == 0; j++) begin
      @(negedge clock);
      a = $urandom; b = $urandom;
      if (done) ndone++;
    end
    chk("hold_result", 64'(result), 64'h30);
    // Second request presented during DONE and the following idle cycle
    a = 32'h100; b = 32'h1; sub = 1;
    @(negedge clock);
    chk("hold_idle_busy", 64'(busy), 0);
    if (done) ndone++;
    chk("hold_single_done", 64'(ndone), 1);
    @(negedge clock);
    chk("accept_after_done", 64'(busy), 1);
    start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 12 && ndone == 0; j++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("second_done", 64'(ndone), 1);
    chk("second_result", 64'(result), 64'hFF);
    chk("second_cout", 64'(carry_out), 1);

    // Abort at the second RUN cycle
    @(negedge clock);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 0; carry_in = 0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    #1 all_zero("abort");
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 0);
    #2 reset = 1'b1;
    do_op(32'h1234_5678, 32'h1111_1111, 0, 0, r, co, ov, dat, seq);
    chk("abort_restart", 64'(r), 64'h2345_6789);

    // Randomized traffic, with occasional asynchronous reset pulses
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      start    = ($urandom_range(0, 2) == 0);
      a        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
      b        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
      sub      = $urandom_range(0, 1) == 1;
      carry_in = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
